// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch_unit
//  Purpose  : Fetches 16-bit instruction words from instruction memory and
//             presents them to the decoder with their PC. Applies the taken
//             branch / jump outcome reported one cycle after decode,
//             retargeting fetch and discarding wrong-path words.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk              in   clock, rising-edge
//    rst_n            in   asynchronous active-low reset
//    o_imem_req       out  fetch request (held until i_imem_gnt)
//    o_imem_addr      out  word address of the request
//    i_imem_gnt       in   request accepted this cycle
//    i_imem_rvalid    in   response data valid
//    i_imem_rdata     in   instruction word
//    o_instr_valid    out  instruction/pc fields valid to decoder
//    o_instr          out  instruction word
//    o_opcode         out  o_instr[15:12]
//    o_function_code  out  o_instr[3:0]
//    o_pc_out         out  address of o_instr
//    i_dec_ready      in   decoder accepts the instruction this cycle
//    i_take_branch    in   previously accepted instruction is a taken branch
//    i_take_jump      in   previously accepted instruction is a jump
// ============================================================================
module instr_fetch_unit #(
   parameter int                ADDR_W   = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              o_imem_req,
   output logic [ADDR_W-1:0] o_imem_addr,
   input  logic              i_imem_gnt,
   input  logic              i_imem_rvalid,
   input  logic [15:0]       i_imem_rdata,
   output logic              o_instr_valid,
   output logic [15:0]       o_instr,
   output logic [3:0]        o_opcode,
   output logic [3:0]        o_function_code,
   output logic [ADDR_W-1:0] o_pc_out,
   input  logic              i_dec_ready,
   input  logic              i_take_branch,
   input  logic              i_take_jump
);

   // Request side
   logic              r_run;      // low only in the first cycle after reset
   logic              r_req;      // request raised, not yet granted
   logic              r_outst;    // request granted, response pending
   logic              r_drop;     // pending response belongs to the wrong path
   logic [ADDR_W-1:0] r_addr;     // address of the current/last request
   logic [ADDR_W-1:0] r_next;     // address the next request will use

   // Output register
   logic              r_valid;
   logic [15:0]       r_instr;
   logic [ADDR_W-1:0] r_pc;

   // Record of the instruction accepted in the previous cycle
   logic              r_acc_valid;
   logic [ADDR_W-1:0] r_acc_pc;
   logic [15:0]       r_acc_instr;

   logic              w_redirect;
   logic [ADDR_W-1:0] w_acc_pc1;
   logic [ADDR_W-1:0] w_br_tgt;
   logic [ADDR_W-1:0] w_jmp_tgt;
   logic [ADDR_W-1:0] w_target;
   logic              w_instr_valid;
   logic              w_accept;
   logic              w_issue;
   logic              w_load;

   assign w_redirect = r_acc_valid & (i_take_branch | i_take_jump);
   assign w_acc_pc1  = r_acc_pc + ADDR_W'(1);
   assign w_br_tgt   = w_acc_pc1 + {{(ADDR_W-4){r_acc_instr[3]}}, r_acc_instr[3:0]};
   assign w_jmp_tgt  = {w_acc_pc1[ADDR_W-1:12], r_acc_instr[11:0]};
   assign w_target   = i_take_jump ? w_jmp_tgt : w_br_tgt;

   // The held word is the wrong path during a redirect, so hide it at once.
   assign w_instr_valid = r_valid & ~w_redirect;
   assign w_accept      = w_instr_valid & i_dec_ready;

   // Issue combinationally so a word accepted this cycle is followed by a
   // request in the same cycle (one instruction per two cycles at best).
   // A redirect cycle never issues: the target request goes out next cycle.
   assign w_issue = r_run & ~r_req & ~r_outst & ~w_redirect & (~r_valid | w_accept);

   // A response arriving in the redirect cycle is wrong-path as well.
   assign w_load = i_imem_rvalid & r_outst & ~r_drop & ~w_redirect;

   assign o_imem_req      = r_req | w_issue;
   assign o_imem_addr     = w_issue ? r_next : r_addr;
   assign o_instr_valid   = w_instr_valid;
   assign o_instr         = r_instr;
   assign o_opcode        = r_instr[15:12];
   assign o_function_code = r_instr[3:0];
   assign o_pc_out        = r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run   <= 1'b0;
         r_req   <= 1'b0;
         r_outst <= 1'b0;
         r_drop  <= 1'b0;
         r_addr  <= RESET_PC;
         r_next  <= RESET_PC;
      end else begin
         r_run <= 1'b1;
         if (w_issue) begin
            r_addr <= r_next;
            r_next <= r_next + ADDR_W'(1);
            if (i_imem_gnt) begin
               r_outst <= 1'b1;
            end else begin
               r_req <= 1'b1;
            end
         end else if (r_req && i_imem_gnt) begin
            r_req   <= 1'b0;
            r_outst <= 1'b1;
         end
         if (r_outst && i_imem_rvalid) begin
            r_outst <= 1'b0;
            r_drop  <= 1'b0;
         end
         if (w_redirect) begin
            r_next <= w_target;
            // Still ungranted: swap the address in place, keep the request up.
            if (r_req && !i_imem_gnt) begin
               r_addr <= w_target;
               r_next <= w_target + ADDR_W'(1);
            end
            // Granted but not yet answered: discard its response when it comes.
            if ((r_req && i_imem_gnt) || (r_outst && !i_imem_rvalid)) begin
               r_drop <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid     <= 1'b0;
         r_instr     <= 16'h0000;
         r_pc        <= '0;
         r_acc_valid <= 1'b0;
         r_acc_pc    <= '0;
         r_acc_instr <= 16'h0000;
      end else begin
         if (w_load) begin
            r_valid <= 1'b1;
            r_instr <= i_imem_rdata;
            r_pc    <= r_addr;
         end else if (w_accept || w_redirect) begin
            r_valid <= 1'b0;
         end
         r_acc_valid <= w_accept;
         if (w_accept) begin
            r_acc_pc    <= r_pc;
            r_acc_instr <= r_instr;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch_unit
//  Purpose  : Self-checking bench for instr_fetch_unit. A behavioural
//             instruction memory answers requests; expected (pc, word) pairs
//             are queued per scenario and compared on every decoder accept.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_fetch_unit;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ins;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [15:0] imem_rdata = 16'h0000;
   logic        instr_valid;
   logic [15:0] instr;
   logic [3:0]  opcode;
   logic [3:0]  function_code;
   logic [15:0] pc_out;
   logic        dec_ready = 1'b0;
   logic        take_branch = 1'b0;
   logic        take_jump = 1'b0;

   int errors = 0;
   int checks = 0;

   exp_t sb[$];
   exp_t mon_e;
   bit   acc_seen = 1'b0;

   logic [15:0] mem_ovr [int];

   // Memory model configuration
   int gnt_delay = 0;
   int resp_lat  = 1;
   bit rand_mem  = 1'b0;
   int viol      = 0;

   // Run configuration
   int          rdy_pct = 100;
   bit          ghost   = 1'b0;
   logic [15:0] rd_pc   [2];
   logic [1:0]  rd_kind [2];   // bit0 branch, bit1 jump
   bit          rd_live [2];

   instr_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .o_imem_req      (imem_req),
      .o_imem_addr     (imem_addr),
      .i_imem_gnt      (imem_gnt),
      .i_imem_rvalid   (imem_rvalid),
      .i_imem_rdata    (imem_rdata),
      .o_instr_valid   (instr_valid),
      .o_instr         (instr),
      .o_opcode        (opcode),
      .o_function_code (function_code),
      .o_pc_out        (pc_out),
      .i_dec_ready     (dec_ready),
      .i_take_branch   (take_branch),
      .i_take_jump     (take_jump)
   );

   always #10 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
      return a ^ 16'hC3A0;
   endfunction

   // Instruction memory: one response slot, grant after a configurable wait.
   initial begin
      bit          have_resp;
      bit          hr0;
      bit          req_seen;
      int          resp_cd;
      int          wait_cnt;
      int          cur_gd;
      int          cur_lat;
      logic [15:0] resp_addr;
      have_resp = 0; req_seen = 0; resp_cd = 0; wait_cnt = 0;
      cur_gd = 0; cur_lat = 1; resp_addr = 16'h0;
      forever begin
         @(negedge clk);
         #1;
         imem_gnt    = 1'b0;
         imem_rvalid = 1'b0;
         if (!rst_n) begin
            have_resp = 0; req_seen = 0; wait_cnt = 0;
         end else begin
            hr0 = have_resp;
            if (have_resp) begin
               if (resp_cd == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = mem_word(resp_addr);
                  have_resp   = 0;
               end else begin
                  resp_cd--;
               end
            end
            if (imem_req) begin
               if (hr0) viol++;
               if (!req_seen) begin
                  cur_gd   = rand_mem ? int'($urandom_range(0, 2)) : gnt_delay;
                  cur_lat  = rand_mem ? int'($urandom_range(1, 3)) : resp_lat;
                  req_seen = 1;
               end
               if (wait_cnt >= cur_gd) begin
                  imem_gnt  = 1'b1;
                  have_resp = 1;
                  resp_addr = imem_addr;
                  resp_cd   = cur_lat - 1;
                  wait_cnt  = 0;
                  req_seen  = 0;
               end else begin
                  wait_cnt++;
               end
            end
         end
      end
   end

   // Scoreboard: every decoder accept must match the oldest expected entry.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         acc_seen = 1'b0;
         if (rst_n && instr_valid && dec_ready) begin
            acc_seen = 1'b1;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no accept", pc_out, instr);
            end else begin
               mon_e = sb.pop_front();
               if ({pc_out, instr, opcode, function_code} !==
                   {mon_e.pc, mon_e.ins, mon_e.ins[15:12], mon_e.ins[3:0]}) begin
                  errors++;
                  $display("FAIL sb_accept: got pc=%h instr=%h op=%h fc=%h, expected pc=%h instr=%h",
                           pc_out, instr, opcode, function_code, mon_e.pc, mon_e.ins);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic push_exp(input logic [15:0] pc);
      exp_t e;
      e.pc  = pc;
      e.ins = mem_word(pc);
      sb.push_back(e);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      dec_ready = 1'b0; take_branch = 1'b0; take_jump = 1'b0;
      sb.delete();
      rd_live[0] = 1'b0; rd_live[1] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic start(input int gd, input int lat, input bit rnd, input int rdy, input bit gh);
      gnt_delay = gd; resp_lat = lat; rand_mem = rnd; rdy_pct = rdy; ghost = gh;
      apply_reset();
   endtask

   // Drives the decoder side until the scoreboard drains; redirects fire one
   // cycle after the configured pc is accepted, and the first request after
   // a redirect must carry the target address.
   task automatic run_to(input int budget);
      int          n;
      bit          done;
      bit          prev_acc;
      bit          tgt_pend;
      bit          fired;
      logic [15:0] prev_pc;
      logic [15:0] prev_ins;
      logic [15:0] pc1;
      logic [15:0] tgt;
      n = 0; done = 0; prev_acc = 0; tgt_pend = 0; fired = 0;
      prev_pc = 16'h0; prev_ins = 16'h0; pc1 = 16'h0; tgt = 16'h0;
      while (!done && n < budget) begin
         @(negedge clk);
         take_branch = 1'b0; take_jump = 1'b0; fired = 0;
         if (prev_acc) begin
            for (int k = 0; k < 2; k++) begin
               if (rd_live[k] && rd_pc[k] == prev_pc) begin
                  rd_live[k]  = 1'b0;
                  fired       = 1;
                  take_branch = rd_kind[k][0];
                  take_jump   = rd_kind[k][1];
                  pc1 = prev_pc + 16'd1;
                  if (take_jump) tgt = {pc1[15:12], prev_ins[11:0]};
                  else           tgt = pc1 + {{12{prev_ins[3]}}, prev_ins[3:0]};
               end
            end
         end else if (ghost) begin
            take_jump = 1'b1;
         end
         dec_ready = (int'($urandom_range(0, 99)) < rdy_pct);
         #3;
         if (tgt_pend && imem_req) begin
            checks++;
            if (imem_addr !== tgt) begin
               errors++;
               $display("FAIL redirect_addr: got imem_addr=%h, expected %h", imem_addr, tgt);
            end
            tgt_pend = 0;
         end
         if (fired) tgt_pend = 1;
         prev_acc = acc_seen;
         prev_pc  = pc_out;
         prev_ins = instr;
         if (acc_seen && sb.size() == 0) done = 1;
         n++;
      end
      @(negedge clk);
      dec_ready = 1'b0; take_branch = 1'b0; take_jump = 1'b0;
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL run_timeout: %0d entries still expected after %0d cycles", sb.size(), n);
      end
      checks++;
      if (tgt_pend !== 1'b0) begin
         errors++;
         $display("FAIL redirect_missing: no request seen for target %h", tgt);
      end
   endtask

   task automatic test_reset();
      gnt_delay = 0; resp_lat = 1; rand_mem = 0;
      @(negedge clk);
      rst_n = 1'b0; dec_ready = 1'b0; sb.delete();
      repeat (2) @(negedge clk);
      #5;
      checks++;
      if ({imem_req, imem_addr} !== 17'h0) begin
         errors++;
         $display("FAIL reset_imem: got req=%b addr=%h, expected 0/0000", imem_req, imem_addr);
      end
      checks++;
      if ({instr_valid, instr, opcode, function_code, pc_out} !== 41'h0) begin
         errors++;
         $display("FAIL reset_dec: got valid=%b instr=%h op=%h fc=%h pc=%h, expected all 0",
                  instr_valid, instr, opcode, function_code, pc_out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
         errors++;
         $display("FAIL first_req: got req=%b addr=%h, expected 1/0000", imem_req, imem_addr);
      end
      @(posedge clk); #1;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL latency_early: got instr_valid=%b one cycle after req, expected 0", instr_valid);
      end
      @(posedge clk); #1;
      checks++;
      if ({instr_valid, pc_out, instr} !== {1'b1, 16'h0000, 16'h0123}) begin
         errors++;
         $display("FAIL latency: got valid=%b pc=%h instr=%h, expected 1/0000/0123",
                  instr_valid, pc_out, instr);
      end
   endtask

   task automatic test_stream();
      start(0, 1, 0, 100, 0);
      for (int p = 0; p < 5; p++) push_exp(16'(p));
      run_to(40);
   endtask

   task automatic test_stall();
      int  n;
      bit  seen;
      start(1, 2, 0, 0, 0);
      n = 0; seen = 0;
      while (!seen && n < 20) begin
         @(negedge clk); #3;
         seen = instr_valid;
         n++;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL stall_wait: got no instr_valid in %0d cycles, expected one", n);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #3;
         checks++;
         if ({instr_valid, imem_req, pc_out, instr} !== {1'b1, 1'b0, 16'h0000, 16'h0123}) begin
            errors++;
            $display("FAIL stall_hold: cycle %0d got valid=%b req=%b pc=%h instr=%h, expected 1/0/0000/0123",
                     c, instr_valid, imem_req, pc_out, instr);
         end
      end
      for (int p = 0; p < 4; p++) push_exp(16'(p));
      rdy_pct = 100;
      run_to(60);
   endtask

   task automatic test_branch();
      int gd_tab  [3] = '{0, 0, 2};
      int lat_tab [3] = '{1, 3, 1};
      for (int c = 0; c < 3; c++) begin
         start(gd_tab[c], lat_tab[c], 0, 100, 0);
         for (int p = 0; p < 5; p++) push_exp(16'(p));
         push_exp(16'h0003);
         rd_pc[0] = 16'h0004; rd_kind[0] = 2'b01; rd_live[0] = 1'b1;
         run_to(80);
      end
   endtask

   task automatic test_jump();
      start(0, 1, 0, 100, 1);
      for (int p = 0; p < 4; p++) push_exp(16'(p));
      for (int p = 16'h0FFD; p <= 16'h1005; p++) push_exp(16'(p));
      push_exp(16'h1ABC);
      push_exp(16'h1ABD);
      rd_pc[0] = 16'h0003; rd_kind[0] = 2'b10; rd_live[0] = 1'b1;
      rd_pc[1] = 16'h1005; rd_kind[1] = 2'b11; rd_live[1] = 1'b1;
      run_to(120);
   endtask

   task automatic test_back_to_back();
      start(0, 1, 1, 60, 0);
      for (int p = 0; p < 7; p++) push_exp(16'(p));
      for (int p = 13; p < 16; p++) push_exp(16'(p));
      rd_pc[0] = 16'h0006; rd_kind[0] = 2'b01; rd_live[0] = 1'b1;
      run_to(300);
   endtask

   task automatic test_async_reset();
      start(0, 4, 0, 100, 0);
      push_exp(16'h0000);
      push_exp(16'h0001);
      run_to(60);
      #5;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({imem_req, imem_addr, instr_valid, instr, pc_out} !== 50'h0) begin
         errors++;
         $display("FAIL async_reset: got req=%b addr=%h valid=%b instr=%h pc=%h, expected all 0",
                  imem_req, imem_addr, instr_valid, instr, pc_out);
      end
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int p = 0; p < 3; p++) push_exp(16'(p));
      run_to(80);
   endtask

   task automatic test_protocol();
      checks++;
      if (viol !== 0) begin
         errors++;
         $display("FAIL one_outstanding: got %0d requests while a response was pending, expected 0", viol);
      end
   endtask

   initial begin
      mem_ovr[16'h0000] = 16'h0123;
      mem_ovr[16'h0001] = 16'h1456;
      mem_ovr[16'h0002] = 16'h2789;
      mem_ovr[16'h0003] = 16'h5FFD;
      mem_ovr[16'h0004] = 16'h412E;
      mem_ovr[16'h1005] = 16'h6ABC;
      rd_live[0] = 1'b0; rd_live[1] = 1'b0;
      rd_pc[0] = 16'h0; rd_pc[1] = 16'h0;
      rd_kind[0] = 2'b00; rd_kind[1] = 2'b00;

      test_reset();
      test_stream();
      test_stall();
      test_branch();
      test_jump();
      test_back_to_back();
      test_async_reset();
      test_protocol();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
